// File: rtl/hilo_divider_pkg.sv
// Shared constants and helpers for the HI/LO divider: FSM encodings,
// iteration count and two's-complement sign helpers.
package hilo_divider_pkg;

    localparam int unsigned DIV_ITERS = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;

    // Count value of the final CALC iteration
    localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

    typedef logic [31:0] word_t;

    // Two's-complement negate when neg is set, pass through otherwise
    function automatic word_t neg_if(input word_t val, input logic neg);
        word_t res;
        if (neg) begin
            res = ~val + 32'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

    // Magnitude as unsigned; |0x80000000| stays 0x80000000
    function automatic word_t abs_word(input word_t val);
        return neg_if(val, val[31]);
    endfunction

endpackage

// File: rtl/hilo_divider_if.sv
// Execute-stage view of the divider: DIV/MFHI/MFLO requests in,
// busy/stall and the HI/LO register contents out.
interface hilo_divider_if;

    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        hilo_read;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, dividend, divisor, hilo_read,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, dividend, divisor, hilo_read,
        output busy, stall, hi, lo
    );

endinterface

// File: rtl/hilo_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when it is non-negative.
module hilo_divider_div_step (
    input  logic [32:0] rem_in,
    input  logic        next_bit,
    input  logic [31:0] divisor,
    output logic [32:0] rem_out,
    output logic        q_bit
);

    logic [33:0] shifted_s;
    logic [33:0] diff_s;

    // Shift, trial-subtract and select the surviving remainder
    always_comb begin
        shifted_s = {rem_in, next_bit};
        diff_s    = shifted_s - {2'b00, divisor};
        if (diff_s[33]) begin
            rem_out = shifted_s[32:0];
            q_bit   = 1'b0;
        end else begin
            rem_out = diff_s[32:0];
            q_bit   = 1'b1;
        end
    end

endmodule

// File: rtl/hilo_divider.sv
// Multi-cycle signed divider owning HI/LO. Divides magnitudes with a
// 32-iteration restoring loop, then applies the sign fixup on commit.
// The pipeline is stalled on DIV or HI/LO reads while a division runs.
module hilo_divider
    import hilo_divider_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    hilo_divider_if.slave  bus
);

    logic [1:0]  state_r;
    logic [4:0]  count_r;
    logic [32:0] rem_r;
    logic [31:0] quo_r;      // holds |dividend|, shifts into the quotient
    logic [31:0] dvs_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        dvd_neg_r;
    logic        dvs_neg_r;
    logic        div0_r;

    logic [32:0] step_rem_s;
    logic        step_q_s;
    logic        busy_s;

    hilo_divider_div_step u_step (
        .rem_in   (rem_r),
        .next_bit (quo_r[31]),
        .divisor  (dvs_r),
        .rem_out  (step_rem_s),
        .q_bit    (step_q_s)
    );

    assign busy_s    = (state_r != ST_IDLE);
    assign bus.busy  = busy_s;
    assign bus.stall = busy_s & (bus.start | bus.hilo_read);
    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;

    // Division FSM, iteration datapath and HI/LO commit
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            count_r   <= 5'd0;
            rem_r     <= 33'd0;
            quo_r     <= 32'd0;
            dvs_r     <= 32'd0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            dvd_neg_r <= 1'b0;
            dvs_neg_r <= 1'b0;
            div0_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        dvd_neg_r <= bus.dividend[31];
                        dvs_neg_r <= bus.divisor[31];
                        quo_r     <= abs_word(bus.dividend);
                        dvs_r     <= abs_word(bus.divisor);
                        div0_r    <= (bus.divisor == 32'd0);
                        rem_r     <= 33'd0;
                        count_r   <= 5'd0;
                        state_r   <= ST_CALC;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    rem_r   <= step_rem_s;
                    quo_r   <= {quo_r[30:0], step_q_s};
                    count_r <= count_r + 5'd1;
                    if (count_r == LAST_ITER) begin
                        state_r <= ST_FIXUP;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                ST_FIXUP: begin
                    // With a zero divisor every trial subtract succeeds, so the
                    // remainder is |dividend| and re-signing it restores the raw
                    // dividend; only the quotient needs the all-ones override.
                    hi_r <= neg_if(rem_r[31:0], dvd_neg_r);
                    if (div0_r) begin
                        lo_r <= 32'hFFFF_FFFF;
                    end else begin
                        lo_r <= neg_if(quo_r, dvd_neg_r ^ dvs_neg_r);
                    end
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
